// File: rtl/pe_seq_ctrl_if.sv
// Bundle of job, stream, result and PE-control signals between the sequencer and its environment.
// slave is the sequencer's view; master is the environment (job source, streams, PE) view.
interface pe_seq_ctrl_if #(
    parameter int unsigned IN_PRECISION  = 16,
    parameter int unsigned OUT_PRECISION = 16,
    parameter int unsigned REG_SIZE      = 4,
    parameter int unsigned LEN_W         = 8
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [LEN_W-1:0]         cmd_len;
    logic [REG_SIZE-1:0]      cmd_nwgt;

    logic                     act_valid;
    logic                     act_ready;
    logic [IN_PRECISION-1:0]  act_data;

    logic                     wgt_valid;
    logic                     wgt_ready;
    logic [IN_PRECISION-1:0]  wgt_data;

    logic [IN_PRECISION-1:0]  pe_act;
    logic [IN_PRECISION-1:0]  pe_wgt;
    logic                     pe_store;
    logic                     pe_reuse;
    logic                     pe_finish;
    logic [REG_SIZE-1:0]      pe_addr;
    logic [OUT_PRECISION-1:0] pe_out;

    logic                     res_valid;
    logic                     res_ready;
    logic [OUT_PRECISION-1:0] res_data;
    logic                     busy;

    modport slave (
        input  cmd_valid, cmd_len, cmd_nwgt, act_valid, act_data, wgt_valid, wgt_data,
               pe_out, res_ready,
        output cmd_ready, act_ready, wgt_ready, pe_act, pe_wgt, pe_store, pe_reuse,
               pe_finish, pe_addr, res_valid, res_data, busy
    );

    modport master (
        output cmd_valid, cmd_len, cmd_nwgt, act_valid, act_data, wgt_valid, wgt_data,
               pe_out, res_ready,
        input  cmd_ready, act_ready, wgt_ready, pe_act, pe_wgt, pe_store, pe_reuse,
               pe_finish, pe_addr, res_valid, res_data, busy
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for a single MAC processing element: optional weight preload, activation
// streaming (reuse or paired-stream mode), finish pulse, result capture and response handshake.
module pe_seq_ctrl #(
    parameter int unsigned IN_PRECISION  = 16,
    parameter int unsigned OUT_PRECISION = 16,
    parameter int unsigned REG_SIZE      = 4,
    parameter int unsigned LEN_W         = 8
) (
    input logic          clk,
    input logic          rst,
    pe_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StMac, StFin, StCapt, StResp} state_e;

    localparam int unsigned         KMaxInt = REG_SIZE - 1;
    localparam logic [REG_SIZE-1:0] KMax    = KMaxInt[REG_SIZE-1:0];
    localparam logic [REG_SIZE-1:0] AddrOne = {{(REG_SIZE-1){1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         n_q, n_d, cnt_q, cnt_d;
    logic [REG_SIZE-1:0]      k_q, k_d, addr_q, addr_d, k_cmd;
    logic [OUT_PRECISION-1:0] res_q, res_d;

    logic                     cmd_ready, act_ready, wgt_ready, res_valid, beat;
    logic                     pe_store, pe_reuse, pe_finish;
    logic [IN_PRECISION-1:0]  pe_act, pe_wgt;
    logic [REG_SIZE-1:0]      pe_addr;

    // PE register 0 is reserved, so at most REG_SIZE-1 weights can be preloaded.
    assign k_cmd = (bus.cmd_nwgt > KMax) ? KMax : bus.cmd_nwgt;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        res_d     = res_q;
        cmd_ready = 1'b0;
        act_ready = 1'b0;
        wgt_ready = 1'b0;
        res_valid = 1'b0;
        pe_store  = 1'b0;
        pe_reuse  = 1'b0;
        pe_finish = 1'b0;
        pe_act    = '0;
        pe_wgt    = '0;
        pe_addr   = '0;
        beat      = 1'b0;

        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    n_d    = bus.cmd_len;
                    k_d    = k_cmd;
                    cnt_d  = '0;
                    addr_d = AddrOne;
                    if (k_cmd != '0) begin
                        state_d = StLoad;
                    end else if (bus.cmd_len != '0) begin
                        state_d = StMac;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StLoad: begin
                wgt_ready = 1'b1;
                pe_addr   = addr_q;
                if (bus.wgt_valid) begin
                    pe_store = 1'b1;
                    pe_wgt   = bus.wgt_data;
                    if (addr_q == k_q) begin
                        addr_d  = AddrOne;
                        state_d = (n_q != '0) ? StMac : StFin;
                    end else begin
                        addr_d = addr_q + AddrOne;
                    end
                end
            end
            StMac: begin
                if (k_q != '0) begin
                    act_ready = 1'b1;
                    pe_addr   = addr_q;
                    if (bus.act_valid) begin
                        beat     = 1'b1;
                        pe_act   = bus.act_data;
                        pe_reuse = 1'b1;
                        addr_d   = (addr_q == k_q) ? AddrOne : addr_q + AddrOne;
                    end
                end else begin
                    // Cross-coupled readies make both streams fire in the same cycle.
                    act_ready = bus.wgt_valid;
                    wgt_ready = bus.act_valid;
                    if (bus.act_valid && bus.wgt_valid) begin
                        beat   = 1'b1;
                        pe_act = bus.act_data;
                        pe_wgt = bus.wgt_data;
                    end
                end
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == n_q) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                pe_finish = 1'b1;
                state_d   = StCapt;
            end
            StCapt: begin
                res_d   = bus.pe_out;
                state_d = StResp;
            end
            StResp: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            res_q   <= res_d;
        end
    end

    // Everything is held at zero while rst is high, including cmd_ready.
    assign bus.cmd_ready = cmd_ready & ~rst;
    assign bus.act_ready = act_ready & ~rst;
    assign bus.wgt_ready = wgt_ready & ~rst;
    assign bus.res_valid = res_valid & ~rst;
    assign bus.pe_store  = pe_store & ~rst;
    assign bus.pe_reuse  = pe_reuse & ~rst;
    assign bus.pe_finish = pe_finish & ~rst;
    assign bus.pe_act    = rst ? '0 : pe_act;
    assign bus.pe_wgt    = rst ? '0 : pe_wgt;
    assign bus.pe_addr   = rst ? '0 : pe_addr;
    assign bus.res_data  = rst ? '0 : res_q;
    assign bus.busy      = (state_q != StIdle) & ~rst;
endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameters SHALL be: IN_PRECISION, default 16, act/wgt width; OUT_PRECISION, default 16, result width; REG_SIZE, default 4, PE regfile depth, also PE addr width; LEN_W, default 8, dot-product length width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high; the same rst SHALL also drive the attached PE.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  job handshake; cmd_len in LEN_W = activation count N; cmd_nwgt in REG_SIZE = preload count K.
REQ-005 act_valid/act_ready  in/out  1/1; act_data  in  IN_PRECISION  activation stream.
REQ-006 wgt_valid/wgt_ready  in/out  1/1; wgt_data  in  IN_PRECISION  weight stream.
REQ-007 pe_act, pe_wgt  out  IN_PRECISION; pe_store, pe_reuse, pe_finish  out  1; pe_addr  out  REG_SIZE; pe_out  in  OUT_PRECISION  PE control and data.
REQ-008 res_valid/res_ready  out/in  1/1; res_data  out  OUT_PRECISION  result; busy  out  1  high whenever state != IDLE.

Function
REQ-009 FSM states SHALL be IDLE, LOAD, MAC, FIN, CAPT, RESP.
REQ-010 IDLE: cmd_ready=1; on cmd_valid, latch N and K, with K clamped to REG_SIZE-1; go to LOAD if K>0, else to MAC if N>0, else to FIN.
REQ-011 LOAD: wgt_ready=1, pe_act=0; each wgt handshake drives pe_store=1, pe_wgt=wgt_data, pe_addr=1,2,...,K.
REQ-012 LOAD SHALL go to MAC (or to FIN if N=0) in the cycle after the K-th handshake.
REQ-013 MAC, reuse mode (K>0): act_ready=1, wgt_ready=0.
REQ-014 Each act handshake in reuse mode drives pe_act=act_data, pe_reuse=1, pe_addr cycling 1..K and wrapping K->1; the address advances only on a handshake.
REQ-015 MAC, stream mode (K=0): act_ready=wgt_valid and wgt_ready=act_valid, so both streams fire together; each beat drives pe_act=act_data, pe_wgt=wgt_data, pe_reuse=0.
REQ-016 Any MAC cycle without a beat SHALL drive pe_act=0, pe_wgt=0, pe_reuse=0 (adds zero).
REQ-017 MAC SHALL go to FIN in the cycle after the N-th beat.
REQ-018 FIN: exactly one cycle with pe_finish=1, pe_act=0, pe_store=0; the PE's MAC in a finish cycle is discarded, so no data beat SHALL coincide with finish.
REQ-019 CAPT: one cycle; register pe_out into res_data.
REQ-020 RESP: res_valid=1 and res_data held stable until res_ready; on the handshake go to IDLE.
REQ-021 No new command SHALL be accepted before the RESP handshake completes; a back-to-back cmd_valid is taken at the first IDLE cycle.
REQ-022 Latency: with all streams always valid, a command accepted in cycle T gives res_valid first in cycle T+K+N+3.
REQ-023 Accumulation SHALL wrap modulo 2^OUT_PRECISION, with no saturation.
REQ-024 pe_store, pe_reuse, pe_finish, act_ready, wgt_ready SHALL be 0 in every state not listed above for them.
REQ-025 Outputs SHALL be decoded combinationally from state plus counters; no ready output SHALL depend on its own valid.
REQ-026 Weights in PE regs 1..K SHALL persist across jobs; no job clears them.

Reset
REQ-027 rst SHALL force IDLE and clear counters, N, K and res_data.
REQ-028 While rst is high, every output SHALL be 0 except cmd_ready, which SHALL be 1 from the first cycle after rst deasserts.
REQ-029 rst asserted mid-job (any state) SHALL abort the job with no result, and the next job SHALL see a cleared PE accumulator.

Verification
REQ-030 Stream: K=0, N=3, act 1,2,3, wgt 4,5,6, all valid -> res_data=32, res_valid at T+6.
REQ-031 Reuse: K=2, wgt 3,5, N=4, act 1,1,2,2 -> pe_addr 1,2,1,2; res_data=24; res_valid at T+9.
REQ-032 Stalls: case REQ-030 with act_valid low in alternate cycles -> res_data=32, zero-add cycles, no dropped or duplicated beat.
REQ-033 Edge: N=0, K=0 -> FIN, CAPT, RESP, res_data=0. cmd_nwgt=7 with REG_SIZE=4 -> clamped to K=3.
REQ-034 Backpressure: res_ready low 5 cycles -> res_data stable, cmd_ready=0 throughout. A second job then gives its own correct sum with no carry-over.
REQ-035 Reset: rst pulse during MAC after 2 beats -> IDLE, no res_valid; next job K=0, N=1, 2*7 -> 14.
